reqack_source_fifo: RTL and testbench

REQACK_SOURCE_FIFO -- requirements
Module: reqack_source_fifo

---
 rtl/reqack_source_fifo.sv | 67 ++++++
 tb/tb_reqack_source_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/reqack_source_fifo.sv
// Responder end of a req/ack handshake, serving words from an internal FIFO.
// Each pop raises ack for one cycle and registers the head word onto dout.
module reqack_source_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     req,
  output logic                     ack,
  output logic [DATA_WIDTH-1:0]    dout,
  input  logic                     stall,
  output logic [$clog2(DEPTH):0]   level,
  output logic [31:0]              sent
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_wr;
  logic                  do_pop;

  // Both strobes look only at registered state, so a pop never frees a slot
  // for a write on the same edge and a fresh write is never popped at once.
  assign wr_ready = (level < FULL_LEVEL);
  assign do_wr    = wr_valid && wr_ready;
  assign do_pop   = req && !ack && !stall && (level != '0);

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ack    <= 1'b0;
      dout   <= '0;
      sent   <= '0;
      level  <= '0;
    end else begin
      ack <= do_pop;
      if (do_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        dout   <= mem[rd_ptr];
        sent   <= sent + 32'd1;
      end
      case ({do_wr, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_reqack_source_fifo.sv
// Bench for reqack_source_fifo: a vector table, directed corner sequences and
// a randomized stream, all checked against a queue-based reference model.
module tb_reqack_source_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          req;
  logic          ack;
  logic [DW-1:0] dout;
  logic          stall;
  logic [3:0]    level;
  logic [31:0]   sent;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // reference model state
  logic [DW-1:0] mq[$];
  logic          m_ack;
  logic [DW-1:0] m_dout;
  logic [31:0]   m_sent;

  reqack_source_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .req(req), .ack(ack), .dout(dout), .stall(stall),
    .level(level), .sent(sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wv;
    logic [DW-1:0] wd;
    logic          rq;
    logic          sl;
    logic          e_ack;
    logic [DW-1:0] e_dout;
    logic [3:0]    e_level;
    logic [31:0]   e_sent;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endtask

  // One clock edge: model advances on pre-edge inputs, DUT sampled 1ns later.
  task automatic cycle();
    logic acc;
    logic pop;
    acc = wr_valid && (mq.size() < DEPTH);
    pop = req && !m_ack && !stall && (mq.size() != 0);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_ack  = 1'b0;
      m_dout = '0;
      m_sent = '0;
    end else begin
      if (pop) begin
        m_dout = mq.pop_front();
        m_sent = m_sent + 32'd1;
      end
      m_ack = pop;
      if (acc) mq.push_back(wr_data);
    end
    #1;
    chk("m_ack", 64'(ack), 64'(m_ack));
    chk("m_dout", 64'(dout), 64'(m_dout));
    chk("m_level", 64'(level), 64'(mq.size()));
    chk("m_wr_ready", 64'(wr_ready), 64'(mq.size() < DEPTH));
    chk("m_sent", 64'(sent), 64'(m_sent));
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; req = 1'b0; stall = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int next_wr;
    int exp_rd;
    logic acc;

    m_ack = 1'b0; m_dout = '0; m_sent = '0;
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; req = 1'b0; stall = 1'b0;
    @(posedge clk);
    do_reset();
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    chk("rst_level", 64'(level), 64'd0);

    // empty FIFO, req held: nothing is served
    req = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    chk("empty_ack", 64'(ack), 64'd0);
    chk("empty_dout", 64'(dout), 64'd0);
    chk("empty_sent", 64'(sent), 64'd0);

    // table: write 1,2,3 back-to-back while the initiator requests
    do_reset();
    tbl[0] = '{1'b1, 32'd1, 1'b1, 1'b0, 1'b0, 32'd0, 4'd1, 32'd0};
    tbl[1] = '{1'b1, 32'd2, 1'b1, 1'b0, 1'b1, 32'd1, 4'd1, 32'd1};
    tbl[2] = '{1'b1, 32'd3, 1'b0, 1'b0, 1'b0, 32'd1, 4'd2, 32'd1};
    tbl[3] = '{1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd2, 4'd1, 32'd2};
    tbl[4] = '{1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd2, 4'd1, 32'd2};
    tbl[5] = '{1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd3, 4'd0, 32'd3};
    tbl[6] = '{1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd3, 4'd0, 32'd3};
    tbl[7] = '{1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd3, 4'd0, 32'd3};
    for (int i = 0; i < 8; i++) begin
      wr_valid = tbl[i].wv; wr_data = tbl[i].wd; req = tbl[i].rq; stall = tbl[i].sl;
      cycle();
      chk($sformatf("tbl%0d_ack", i), 64'(ack), 64'(tbl[i].e_ack));
      chk($sformatf("tbl%0d_dout", i), 64'(dout), 64'(tbl[i].e_dout));
      chk($sformatf("tbl%0d_level", i), 64'(level), 64'(tbl[i].e_level));
      chk($sformatf("tbl%0d_sent", i), 64'(sent), 64'(tbl[i].e_sent));
    end

    // overfill with req low, then one pop frees a slot
    do_reset();
    wr_valid = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      wr_data = 32'(100 + i);
      cycle();
    end
    chk("full_wr_ready", 64'(wr_ready), 64'd0);
    chk("full_level", 64'(level), 64'(DEPTH));
    wr_valid = 1'b0; req = 1'b1;
    cycle();
    chk("full_pop_ack", 64'(ack), 64'd1);
    chk("full_pop_dout", 64'(dout), 64'd100);
    chk("full_pop_wr_ready", 64'(wr_ready), 64'd1);
    req = 1'b0; wr_valid = 1'b1; wr_data = 32'd200;
    cycle();
    chk("refill_level", 64'(level), 64'(DEPTH));
    wr_valid = 1'b0;

    // stall holds off a pending request
    do_reset();
    wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 32'(8'hA0 + i);
      cycle();
    end
    wr_valid = 1'b0; req = 1'b1; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_no_ack", 64'(ack), 64'd0);
    end
    stall = 1'b0;
    cycle();
    chk("stall_release_ack", 64'(ack), 64'd1);
    chk("stall_release_dout", 64'(dout), 64'hA0);
    req = 1'b0;

    // reset while ack is high and five words remain
    do_reset();
    wr_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_data = 32'(300 + i);
      cycle();
    end
    wr_valid = 1'b0; req = 1'b1;
    cycle();
    chk("pre_rst_ack", 64'(ack), 64'd1);
    chk("pre_rst_level", 64'(level), 64'd5);
    req = 1'b0; rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mid_rst_ack", 64'(ack), 64'd0);
    chk("mid_rst_dout", 64'(dout), 64'd0);
    chk("mid_rst_level", 64'(level), 64'd0);
    chk("mid_rst_sent", 64'(sent), 64'd0);
    chk("mid_rst_wr_ready", 64'(wr_ready), 64'd1);

    // randomized stream of 5000 incrementing words
    do_reset();
    next_wr = 0;
    exp_rd  = 0;
    req     = 1'b1;
    for (int c = 0; c < 40000 && exp_rd < 5000; c++) begin
      wr_valid = (next_wr < 5000) && ($urandom_range(0, 3) != 0);
      wr_data  = 32'(next_wr);
      stall    = ($urandom_range(0, 7) == 0);
      acc      = wr_valid && (mq.size() < DEPTH);
      cycle();
      if (acc) next_wr++;
      if (ack) begin
        chk("stream_order", 64'(dout), 64'(exp_rd));
        exp_rd++;
        req = 1'b0;
      end else begin
        req = ($urandom_range(0, 3) != 0);
      end
    end
    wr_valid = 1'b0; req = 1'b0; stall = 1'b0;
    chk("stream_done", 64'(exp_rd), 64'd5000);
    chk("stream_sent", 64'(sent), 64'd5000);
    chk("stream_level", 64'(level), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
